// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: accept, one ACCESS cycle, one RESP cycle.
// Optional round-robin arbitration when DMEM_ARB_ROUND_ROBIN_EN is defined; fixed priority (r0 wins) otherwise.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  // state  | meaning
  // IDLE   | waiting for a request; one ready may be high
  // ACCESS | captured request driven onto the memory (aligned only)
  // RESP   | one-cycle response pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nx;
  logic                grant0, grant1;
  logic                accept, accept_id;
  logic                id_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_access, aligned, mem_go;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio_q;

  always_comb begin
    grant0 = r0_valid & (~r1_valid | ~prio_q);
    grant1 = r1_valid & (~r0_valid | prio_q);
  end

  // pointer moves to the requester that just lost (or was not granted)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prio_q <= 1'b0;
    else if (accept) prio_q <= ~accept_id;
  end
`else
  always_comb begin
    grant0 = r0_valid;
    grant1 = r1_valid & ~r0_valid;
  end
`endif

  assign accept    = r0_ready | r1_ready;
  assign accept_id = r1_ready;
  assign in_access = (state == ACCESS);
  assign aligned   = (addr_q[1:0] == 2'b00);
  assign mem_go    = in_access & aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        r0_ready = grant0;
        r1_ready = grant1;
        if (grant0 | grant1) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_en    = mem_go;
        mem_we    = mem_go & we_q;
        mem_addr  = mem_go ? addr_q : '0;
        mem_wdata = mem_go ? wdata_q : '0;
        state_nx  = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      id_q    <= accept_id;
      we_q    <= accept_id ? r1_we    : r0_we;
      addr_q  <= accept_id ? r1_addr  : r0_addr;
      wdata_q <= accept_id ? r1_wdata : r0_wdata;
    end
  end

  // response registers hold zero everywhere except the RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= in_access;
      rsp_id    <= in_access & id_q;
      rsp_err   <= in_access & ~aligned;
      rsp_rdata <= (mem_go & ~we_q) ? mem_rdata : '0;
    end
  end

  assign pipe_stall = r0_valid & ~((state == RESP) & ~rsp_id);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_we;
  logic [31:0] r0_addr, r0_wdata;
  logic        r1_valid, r1_ready, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        pipe_stall;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
  );

  // word-addressed memory behind the arbiter
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  // reference model state
  logic [31:0] ref_mem [0:63];
  logic        model_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        r0v, r1v, we;
    logic [31:0] addr, wdata;
    logic        exp_id, exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, pipe_stall});
  endfunction

  function automatic logic pick(input logic r0v, input logic r1v);
    return (r0v && r1v) ? (RR ? model_ptr : 1'b0) : r1v;
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) * 32'd4;
    if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic drive(input logic r0v, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1v, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    r0_valid = r0v; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = r1v; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  // One full transaction, entered #1 after an edge with the DUT in IDLE; leaves #1 after
  // the edge that returns the DUT to IDLE.
  task automatic txn(input logic r0v, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1v, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic exp_id, input logic exp_err, input logic [31:0] exp_rdata,
                     input logic scramble);
    logic        ewe;
    logic [31:0] ea, ed;
    ewe = exp_id ? we1 : we0;
    ea  = exp_id ? a1  : a0;
    ed  = exp_id ? d1  : d0;
    drive(r0v, we0, a0, d0, r1v, we1, a1, d1);
    #1;
    check("ready_idle", 128'({r0_ready, r1_ready}), exp_id ? 128'(2'b01) : 128'(2'b10));
    check("stall_accept", 128'(pipe_stall), 128'(r0v));
    @(posedge clk); #1;
    check("access_mem_en", 128'(mem_en), 128'(!exp_err));
    check("access_mem_we", 128'(mem_we), 128'(!exp_err && ewe));
    check("access_mem_addr", 128'(mem_addr), exp_err ? 128'(0) : 128'(ea));
    check("access_mem_wdata", 128'(mem_wdata), exp_err ? 128'(0) : 128'(ed));
    check("access_ready", 128'({r0_ready, r1_ready}), 128'(0));
    check("access_stall", 128'(pipe_stall), 128'(r0_valid));
    check("access_rsp_valid", 128'(rsp_valid), 128'(0));
    if (scramble) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      #1;
      check("access_ready_scr", 128'({r0_ready, r1_ready}), 128'(0));
      check("access_addr_scr", 128'(mem_addr), exp_err ? 128'(0) : 128'(ea));
      check("access_wdata_scr", 128'(mem_wdata), exp_err ? 128'(0) : 128'(ed));
      check("access_stall_scr", 128'(pipe_stall), 128'(r0_valid));
    end
    @(posedge clk); #1;
    check("rsp_valid", 128'(rsp_valid), 128'(1));
    check("rsp_id", 128'(rsp_id), 128'(exp_id));
    check("rsp_err", 128'(rsp_err), 128'(exp_err));
    check("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
    check("rsp_mem_en", 128'(mem_en), 128'(0));
    check("rsp_ready", 128'({r0_ready, r1_ready}), 128'(0));
    check("rsp_stall", 128'(pipe_stall), 128'(r0_valid & exp_id));
    if (!exp_err && ewe) ref_mem[ea[7:2]] = ed;
    model_ptr = ~exp_id;
    @(posedge clk); #1;
    check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    check("idle_mem_en", 128'(mem_en), 128'(0));
    check("idle_stall", 128'(pipe_stall), 128'(r0_valid));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("reset_outputs", all_outs(), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 1'b0;
  endtask

  initial begin
    logic        r0v, r1v, we0, we1, w, err;
    logic [31:0] a0, a1, d0, d1, ea;
    int          sel;

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_ptr = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h13, 32'h55AA55AA, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h22, 32'h0,        1'b0, 1'b1, 32'h0};

    do_reset();

    for (int i = 0; i < 7; i++)
      txn(tbl[i].r0v, tbl[i].we, tbl[i].addr, tbl[i].wdata,
          tbl[i].r1v, tbl[i].we, tbl[i].addr, tbl[i].wdata,
          tbl[i].exp_id, tbl[i].exp_err, tbl[i].exp_rdata, 1'b0);

    // both requesters reading continuously from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = RR ? k[0] : 1'b0;
      txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
          w, 1'b0, w ? 32'hCAFEF00D : 32'hDEADBEEF, 1'b0);
    end

    // reset in the middle of a write's ACCESS cycle
    drive(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
    #1;
    check("rst_seq_ready", 128'(r0_ready), 128'(1));
    @(posedge clk); #1;
    check("rst_seq_access_we", 128'({mem_en, mem_we}), 128'(2'b11));
    #2;
    rst = 1'b1;
    r0_valid = 1'b0;
    #1;
    check("rst_async_outputs", all_outs(), 128'(0));
    @(posedge clk); #1;
    check("rst_held_outputs", all_outs(), 128'(0));
    rst = 1'b0;
    model_ptr = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_rsp", all_outs(), 128'(0));
    txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 1)) begin
        drive(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        #1;
        check("novalid_ready", 128'({r0_ready, r1_ready}), 128'(0));
        check("novalid_stall", 128'(pipe_stall), 128'(0));
        @(posedge clk); #1;
      end
      sel = $urandom_range(1, 3);
      r0v = sel[0];
      r1v = sel[1];
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      a0  = gen_addr();
      a1  = gen_addr();
      d0  = $urandom;
      d1  = $urandom;
      w   = pick(r0v, r1v);
      ea  = w ? a1 : a0;
      err = (ea[1:0] != 2'b00);
      txn(r0v, we0, a0, d0, r1v, we1, a1, d1, w, err,
          (!err && !(w ? we1 : we0)) ? ref_mem[ea[7:2]] : 32'h0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
